// File: rtl/mem_responder.sv
// Single-outstanding memory responder with a fixed wait-state count and a one-cycle response pulse.
// Optional feature: define MISALIGN_CHECK_EN to reject non-word-aligned addresses with resp_error.
module mem_responder #(
   parameter int unsigned DEPTH_LOG2  = 8,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error
);

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W     = 4;
   localparam int unsigned WAIT_LAST = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   req_t              req_q, req_d;
   logic              req_ready_q, req_ready_d;
   logic              resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
   logic              resp_error_q, resp_error_d;
   logic              enter_resp;
   logic              misalign;
   logic              mem_we;
   logic [DEPTH_LOG2-1:0] widx;

   logic [DATA_W-1:0] mem [DEPTH];

   // Next-state, request latch and response capture
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      req_d        = req_q;
      enter_resp   = 1'b0;
      misalign     = 1'b0;
      mem_we       = 1'b0;
      widx         = '0;
      resp_rdata_d = resp_rdata_q;
      resp_error_d = resp_error_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               req_d.write = req_write;
               req_d.addr  = req_addr;
               req_d.wdata = req_wdata;
               cnt_d       = '0;
               if (WAIT_CYCLES == 0) begin
                  state_d    = ST_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == CNT_W'(WAIT_LAST)) begin
               state_d    = ST_RESP;
               enter_resp = 1'b1;
               cnt_d      = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // req_d holds the live request on a zero-wait accept and the latched one otherwise
      widx = req_d.addr[DEPTH_LOG2+1:2];
`ifdef MISALIGN_CHECK_EN
      misalign = (req_d.addr[1:0] != 2'b00);
`else
      misalign = 1'b0;
`endif

      if (enter_resp) begin
         if (misalign) begin
            resp_rdata_d = '0;
            resp_error_d = 1'b1;
         end else begin
            mem_we       = req_d.write;
            resp_rdata_d = req_d.write ? req_d.wdata : mem[widx];
            resp_error_d = 1'b0;
         end
      end

      req_ready_d  = (state_d == ST_IDLE);
      resp_valid_d = (state_d == ST_RESP);
   end

   // Control and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         req_q        <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         req_q        <= req_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_error_q <= resp_error_d;
      end
   end

   // Storage array; a reset on the RESP-entry edge aborts the store
   always_ff @(posedge clock) begin
      if (mem_we && !reset) begin
         mem[widx] <= req_d.wdata;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_error = resp_error_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with 2 wait states, one with none.
module tb_mem_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid  [2];
   logic        req_write  [2];
   logic [31:0] req_addr   [2];
   logic [31:0] req_wdata  [2];
   logic        req_ready  [2];
   logic        resp_valid [2];
   logic [31:0] resp_rdata [2];
   logic        resp_error [2];

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid[0]),
      .req_write  (req_write[0]),
      .req_addr   (req_addr[0]),
      .req_wdata  (req_wdata[0]),
      .req_ready  (req_ready[0]),
      .resp_valid (resp_valid[0]),
      .resp_rdata (resp_rdata[0]),
      .resp_error (resp_error[0])
   );

   mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut_w0 (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid[1]),
      .req_write  (req_write[1]),
      .req_addr   (req_addr[1]),
      .req_wdata  (req_wdata[1]),
      .req_ready  (req_ready[1]),
      .resp_valid (resp_valid[1]),
      .resp_rdata (resp_rdata[1]),
      .resp_error (resp_error[1])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One request; returns pulse latency (99 on timeout) and the response captured on the pulse
   task automatic txn(input string tag, input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit hold,
                      output int lat, output logic [31:0] rdata, output logic err);
      int extra;
      @(negedge clock);
      chk({tag, "_ready_pre"}, 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b1;
      req_write[d] = wr;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      @(posedge clock);
      #1;
      if (hold) req_wdata[d] = 32'hBAD0_BAD0;
      else      req_valid[d] = 1'b0;
      lat = 99;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clock);
         if (resp_valid[d]) begin
            lat = n;
            break;
         end
      end
      req_valid[d] = 1'b0;
      rdata = resp_rdata[d];
      err   = resp_error[d];
      chk({tag, "_ready_in_resp"}, 32'(req_ready[d]), 32'd0);
      @(negedge clock);
      chk({tag, "_ready_back"}, 32'(req_ready[d]), 32'd1);
      extra = 0;
      for (int n = 0; n < 4; n++) begin
         if (resp_valid[d]) extra++;
         if (n < 3) @(negedge clock);
      end
      chk({tag, "_extra_pulses"}, 32'(extra), 32'd0);
      chk({tag, "_rdata_hold"}, resp_rdata[d], rdata);
   endtask

   int          lat;
   logic [31:0] rd;
   logic        er;

   initial begin
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0;
         req_write[i] = 1'b0;
         req_addr[i]  = '0;
         req_wdata[i] = '0;
      end
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst%0d_ready", i), 32'(req_ready[i]), 32'd1);
         chk($sformatf("rst%0d_valid", i), 32'(resp_valid[i]), 32'd0);
         chk($sformatf("rst%0d_rdata", i), resp_rdata[i], 32'd0);
         chk($sformatf("rst%0d_error", i), 32'(resp_error[i]), 32'd0);
      end
      reset = 1'b0;

      txn("sw10", 0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, lat, rd, er);
      chk("sw10_lat", 32'(lat), 32'd3);
      chk("sw10_rdata", rd, 32'hDEAD_BEEF);
      chk("sw10_err", 32'(er), 32'd0);
      txn("lw10", 0, 1'b0, 32'h10, 32'h0, 1'b0, lat, rd, er);
      chk("lw10_lat", 32'(lat), 32'd3);
      chk("lw10_rdata", rd, 32'hDEAD_BEEF);
      chk("lw10_err", 32'(er), 32'd0);

      txn("sw400", 0, 1'b1, 32'h400, 32'h1234, 1'b0, lat, rd, er);
      txn("lw000", 0, 1'b0, 32'h000, 32'h0, 1'b0, lat, rd, er);
      chk("wrap_rdata", rd, 32'h1234);

      // Seed word 0x20, then abort a store to it with a reset during WAIT
      txn("sw20a", 0, 1'b1, 32'h20, 32'hAAAA_0000, 1'b0, lat, rd, er);
      @(negedge clock);
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      req_addr[0]  = 32'h20;
      req_wdata[0] = 32'h55;
      @(posedge clock);
      #1;
      req_valid[0] = 1'b0;
      @(negedge clock);
      chk("midrst_busy", 32'(req_ready[0]), 32'd0);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("midrst_ready", 32'(req_ready[0]), 32'd1);
      chk("midrst_valid", 32'(resp_valid[0]), 32'd0);
      chk("midrst_rdata", resp_rdata[0], 32'd0);
      repeat (4) begin
         @(negedge clock);
         chk("midrst_no_pulse", 32'(resp_valid[0]), 32'd0);
      end
      txn("lw20", 0, 1'b0, 32'h20, 32'h0, 1'b0, lat, rd, er);
      chk("midrst_old", rd, 32'hAAAA_0000);

      // Valid held through WAIT with changing data: one response, first data stored
      txn("hold", 0, 1'b1, 32'h30, 32'h77, 1'b1, lat, rd, er);
      chk("hold_lat", 32'(lat), 32'd3);
      chk("hold_rdata", rd, 32'h77);
      txn("lw30", 0, 1'b0, 32'h30, 32'h0, 1'b0, lat, rd, er);
      chk("hold_stored", rd, 32'h77);

      txn("sw22", 0, 1'b1, 32'h22, 32'h99, 1'b0, lat, rd, er);
      chk("sw22_lat", 32'(lat), 32'd3);
`ifdef MISALIGN_CHECK_EN
      chk("sw22_err", 32'(er), 32'd1);
      chk("sw22_rdata", rd, 32'd0);
      txn("lw20b", 0, 1'b0, 32'h20, 32'h0, 1'b0, lat, rd, er);
      chk("misalign_untouched", rd, 32'hAAAA_0000);
`else
      chk("sw22_err", 32'(er), 32'd0);
      chk("sw22_rdata", rd, 32'h99);
      txn("lw20b", 0, 1'b0, 32'h20, 32'h0, 1'b0, lat, rd, er);
      chk("misalign_written", rd, 32'h99);
`endif

      txn("w0_sw8", 1, 1'b1, 32'h8, 32'hCAFE_F00D, 1'b0, lat, rd, er);
      chk("w0_sw8_lat", 32'(lat), 32'd1);
      chk("w0_sw8_rdata", rd, 32'hCAFE_F00D);
      txn("w0_lw8", 1, 1'b0, 32'h8, 32'h0, 1'b0, lat, rd, er);
      chk("w0_lw8_lat", 32'(lat), 32'd1);
      chk("w0_lw8_rdata", rd, 32'hCAFE_F00D);
      chk("w0_lw8_err", 32'(er), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
